handshake_fifo_sink: RTL and testbench
======================================

Name: handshake_fifo_sink

Overview:
- Receiving end of the elastic valid/ready data channel driven by constant and arithmetic producers.
- Accepts tokens on the `ins` channel and stores up to DEPTH of them in FIFO order.
- Re-emits them on the `outs` channel with full decoupling: `ins_ready` does not depend on `outs_ready` in the same cycle.
- Used as the opaque buffer at the consumer side of a dataflow edge to break combinational handshake paths and absorb producer bursts.

Parameters:
- DATA_WIDTH, 32, width of the token payload.
- DEPTH, 4, number of storage slots; power of two, minimum 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- ins  input  DATA_WIDTH  incoming token payload.
- ins_valid  input  1  producer offers a token.
- ins_ready  output  1  FIFO can accept a token this cycle.
- outs  output  DATA_WIDTH  payload of the oldest stored token.
- outs_valid  output  1  at least one token stored.
- outs_ready  input  1  consumer accepts the `outs` token.
- count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.

Behaviour:
- Storage and pointers:
  - Circular buffer of DEPTH entries.
  - Write pointer and read pointer, each $clog2(DEPTH) bits; both wrap modulo DEPTH naturally.
  - Occupancy register `count` is the single source of truth for full and empty.
- Handshake rules:
  - Push happens on a clock edge with ins_valid=1 and ins_ready=1: entry written at the write pointer, write pointer +1.
  - Pop happens on a clock edge with outs_valid=1 and outs_ready=1: read pointer +1.
  - ins_ready = (count != DEPTH), registered-state only, no combinational path from outs_ready.
  - outs_valid = (count != 0), registered-state only, no combinational path from ins_valid.
  - outs = storage[read pointer], combinational read of registered state.
  - outs is don't-care while outs_valid=0; the bench must not check it then.
  - `ins` is sampled only on a push; its value is irrelevant otherwise.
- Latency:
  - A token pushed at edge N is visible on outs with outs_valid=1 after edge N (i.e. during cycle N+1) when the FIFO was empty.
  - No same-cycle bypass from ins to outs.
- Occupancy update per edge:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, both pointers advance.
  - neither: unchanged.
- Boundary conditions:
  - Full (count=DEPTH): ins_ready=0 even if outs_ready=1 that cycle. A pop at that edge frees a slot, and ins_ready returns to 1 on the following cycle.
  - Empty (count=0): outs_valid=0. A push at that edge makes outs_valid=1 next cycle; there is no pop of the incoming token in the same cycle.
  - Pointer wrap from DEPTH-1 to 0 is seamless; FIFO order is preserved across the wrap.
  - Valid stability is required of the producer, not checked: once ins_valid=1 it stays high with `ins` stable until accepted. The block itself guarantees outs_valid and outs stay stable until popped.
- Reset:
  - While rst=0 at a rising edge: count=0, both pointers=0.
  - Next cycle: outs_valid=0 and ins_ready=1.
  - Storage contents are not reset.
  - Reset mid-operation discards all stored tokens; no push or pop occurs on the reset edge regardless of valid/ready.
  - ins_ready is forced to 0 combinationally while rst=0, so no token is lost in flight.

Test Plan:
- Reset then single token: rst=0 for 2 cycles, release; push ins=32'h00000044 with outs_ready=0 → next cycle outs_valid=1, outs=0x44, count=1; assert outs_ready → following cycle outs_valid=0, count=0.
- Fill to full (DEPTH=4): push 0x10,0x11,0x12,0x13 with outs_ready=0 → count=4, ins_ready=0; hold ins_valid=1 with ins=0x14 → not accepted, count stays 4, outs=0x10 stable.
- Full with simultaneous pop: at count=4 assert outs_ready=1 and ins_valid=1 (ins=0x14) → edge pops 0x10 only, count=3; next edge accepts 0x14; drained order is 0x11,0x12,0x13,0x14.
- Streaming push+pop: at count=2, hold ins_valid=1 and outs_ready=1 for 10 cycles with incrementing data 0x20..0x29 → count stays 2 every cycle and output order is exact, covering pointer wrap more than twice.
- Reset mid-operation: at count=3 drive rst=0 for 1 cycle with ins_valid=1 → ins_ready=0 during reset, count=0 and outs_valid=0 afterwards, and no stale data appears on the next push (0x55 emerges first).
- Random backpressure: 200 cycles of random ins_valid/outs_ready at 50% → scoreboard matches in-order data; count never exceeds 4 and never underflows.

Source files
------------

// File: rtl/handshake_fifo_sink.sv
// Consumer-side elastic buffer: DEPTH-entry circular FIFO on a valid/ready channel.
// Both handshake outputs come only from registered occupancy, so ins and outs paths are decoupled.
module handshake_fifo_sink #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_WIDTH-1:0]        ins,
    input  logic                         ins_valid,
    output logic                         ins_ready,
    output logic [DATA_WIDTH-1:0]        outs,
    output logic                         outs_valid,
    input  logic                         outs_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         occ;
    logic [CW-1:0]         occ_next;
    logic                  push;
    logic                  pop;

    // rst gates ins_ready so a producer never sees acceptance on a reset edge.
    assign ins_ready  = rst && (occ != FULL_COUNT);
    assign outs_valid = (occ != '0);
    assign outs       = mem[rd_ptr];
    assign count      = occ;

    assign push = ins_valid && ins_ready;
    assign pop  = outs_valid && outs_ready;

    always_comb begin
        occ_next = occ;
        unique case ({push, pop})
            2'b10:   occ_next = occ + 1'b1;
            2'b01:   occ_next = occ - 1'b1;
            default: occ_next = occ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            occ    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            occ <= occ_next;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Payload storage carries no reset; push already excludes the reset edge.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= ins;
        end
    end

endmodule

// File: tb/tb_handshake_fifo_sink.sv
// Self-checking bench for handshake_fifo_sink with a queue scoreboard of accepted tokens.
module tb_handshake_fifo_sink;

    logic        clk;
    logic        rst;
    logic [31:0] ins;
    logic        ins_valid;
    logic        ins_ready;
    logic [31:0] outs;
    logic        outs_valid;
    logic        outs_ready;
    logic [2:0]  count;

    int checks   = 0;
    int failures = 0;

    logic [31:0] q[$];

    logic        o_ready, o_valid;
    logic [2:0]  o_count;
    logic [31:0] o_outs;
    logic        e_ready, e_valid;
    int          e_count;
    logic        did_pop;
    logic [31:0] pop_exp;

    handshake_fifo_sink #(.DATA_WIDTH(32), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .ins        (ins),
        .ins_valid  (ins_valid),
        .ins_ready  (ins_ready),
        .outs       (outs),
        .outs_valid (outs_valid),
        .outs_ready (outs_ready),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one cycle, samples DUT mid-cycle, then advances the reference queue at the edge.
    task automatic step(input logic v, input logic [31:0] d, input logic r, input logic rs);
        logic push_ok;
        ins_valid  = v;
        ins        = d;
        outs_ready = r;
        rst        = rs;
        @(negedge clk);
        o_ready = ins_ready;
        o_valid = outs_valid;
        o_count = count;
        o_outs  = outs;
        e_ready = rs && (q.size() != 4);
        e_valid = (q.size() != 0);
        e_count = q.size();
        did_pop = 1'b0;
        pop_exp = '0;
        push_ok = v && rs && (q.size() != 4);
        @(posedge clk);
        if (!rs) begin
            q.delete();
        end else begin
            if (r && q.size() != 0) begin
                did_pop = 1'b1;
                pop_exp = q.pop_front();
            end
            if (push_ok) q.push_back(d);
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 32'hdead_beef, 1'b1, 1'b0);
            checks++;
            if (o_ready !== 1'b0) begin
                failures++;
                $display("FAIL reset_ready_low got=%0b want=0", o_ready);
            end
        end
        step(1'b0, 32'h0, 1'b0, 1'b1);
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_count !== 3'd0) begin
            failures++;
            $display("FAIL reset_state got valid=%0b ready=%0b count=%0d want valid=0 ready=1 count=0",
                     o_valid, o_ready, o_count);
        end
    endtask

    task automatic test_single();
        step(1'b1, 32'h0000_0044, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        checks++;
        if (o_valid !== 1'b1 || o_outs !== 32'h44 || o_count !== 3'd1) begin
            failures++;
            $display("FAIL single_visible got valid=%0b outs=%h count=%0d want valid=1 outs=00000044 count=1",
                     o_valid, o_outs, o_count);
        end
        checks++;
        if (!did_pop || o_outs !== pop_exp) begin
            failures++;
            $display("FAIL single_pop got pop=%0b outs=%h want pop=1 outs=%h", did_pop, o_outs, pop_exp);
        end
        step(1'b0, 32'h0, 1'b0, 1'b1);
        checks++;
        if (o_valid !== 1'b0 || o_count !== 3'd0) begin
            failures++;
            $display("FAIL single_empty got valid=%0b count=%0d want valid=0 count=0", o_valid, o_count);
        end
    endtask

    task automatic test_fill_full();
        for (int i = 0; i < 4; i++) step(1'b1, 32'h10 + 32'(i), 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 32'h14, 1'b0, 1'b1);
            checks++;
            if (o_count !== 3'd4 || o_ready !== 1'b0 || o_outs !== 32'h10 || o_valid !== 1'b1) begin
                failures++;
                $display("FAIL full_hold got count=%0d ready=%0b outs=%h valid=%0b want count=4 ready=0 outs=00000010 valid=1",
                         o_count, o_ready, o_outs, o_valid);
            end
        end
    endtask

    task automatic test_full_pop();
        logic [31:0] drain [4];
        drain = '{32'h11, 32'h12, 32'h13, 32'h14};
        step(1'b1, 32'h14, 1'b1, 1'b1);
        checks++;
        if (o_ready !== 1'b0 || o_count !== 3'd4 || !did_pop || o_outs !== 32'h10) begin
            failures++;
            $display("FAIL full_pop got ready=%0b count=%0d pop=%0b outs=%h want ready=0 count=4 pop=1 outs=00000010",
                     o_ready, o_count, did_pop, o_outs);
        end
        step(1'b1, 32'h14, 1'b0, 1'b1);
        checks++;
        if (o_ready !== 1'b1 || o_count !== 3'd3) begin
            failures++;
            $display("FAIL full_reopen got ready=%0b count=%0d want ready=1 count=3", o_ready, o_count);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b1);
            checks++;
            if (!did_pop || o_outs !== drain[i] || pop_exp !== drain[i]) begin
                failures++;
                $display("FAIL full_drain[%0d] got pop=%0b outs=%h want %h", i, did_pop, o_outs, drain[i]);
            end
        end
        step(1'b0, 32'h0, 1'b0, 1'b1);
        checks++;
        if (o_count !== 3'd0 || o_valid !== 1'b0) begin
            failures++;
            $display("FAIL full_drained got count=%0d valid=%0b want count=0 valid=0", o_count, o_valid);
        end
    endtask

    task automatic test_back_to_back();
        step(1'b1, 32'h1e, 1'b0, 1'b1);
        step(1'b1, 32'h1f, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 32'h20 + 32'(i), 1'b1, 1'b1);
            checks++;
            if (o_count !== 3'd2 || !did_pop || o_outs !== pop_exp) begin
                failures++;
                $display("FAIL stream[%0d] got count=%0d pop=%0b outs=%h want count=2 pop=1 outs=%h",
                         i, o_count, did_pop, o_outs, pop_exp);
            end
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b1);
            checks++;
            if (o_outs !== 32'h28 + 32'(i)) begin
                failures++;
                $display("FAIL stream_tail[%0d] got outs=%h want %h", i, o_outs, 32'h28 + 32'(i));
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) step(1'b1, 32'h30 + 32'(i), 1'b0, 1'b1);
        step(1'b1, 32'h99, 1'b1, 1'b0);
        checks++;
        if (o_ready !== 1'b0) begin
            failures++;
            $display("FAIL midreset_ready got=%0b want=0", o_ready);
        end
        step(1'b1, 32'h55, 1'b0, 1'b1);
        checks++;
        if (o_count !== 3'd0 || o_valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_cleared got count=%0d valid=%0b want count=0 valid=0", o_count, o_valid);
        end
        step(1'b0, 32'h0, 1'b1, 1'b1);
        checks++;
        if (o_valid !== 1'b1 || o_outs !== 32'h55 || o_count !== 3'd1) begin
            failures++;
            $display("FAIL midreset_first got valid=%0b outs=%h count=%0d want valid=1 outs=00000055 count=1",
                     o_valid, o_outs, o_count);
        end
        step(1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 200; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b1);
            checks++;
            if (o_ready !== e_ready || o_valid !== e_valid || int'(o_count) != e_count || o_count > 3'd4
                || (did_pop && o_outs !== pop_exp)) begin
                failures++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random[%0d] got ready=%0b valid=%0b count=%0d outs=%h want ready=%0b valid=%0b count=%0d outs=%h",
                             i, o_ready, o_valid, o_count, o_outs, e_ready, e_valid, e_count, pop_exp);
            end
        end
    endtask

    initial begin
        rst        = 1'b0;
        ins        = '0;
        ins_valid  = 1'b0;
        outs_ready = 1'b0;
        #1;
        test_reset();
        test_single();
        test_fill_full();
        test_full_pop();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
